// File: rtl/ifu_multi_pkg.sv
// Shared definitions for the multi-instruction fetch unit: exception codes,
// the NOP used to carry fetch faults, and a block-alignment helper.
package ifu_multi_pkg;

  typedef enum logic [1:0] {
    ADEF   = 2'd0,
    I_TLBR = 2'd1,
    PIF    = 2'd2,
    PPI    = 2'd3
  } excp_t;

  localparam logic [31:0] NOP_INST = 32'h03400000;

  function automatic logic [31:0] blk_align(input logic [31:0] pc, input int unsigned fetch_w);
    return pc & ~(32'(fetch_w * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/ifu_multi_fetch_inflight_fifo.sv
// In-order tracker for outstanding fetch requests. Each entry carries a stale
// bit so that a redirect can discard in-flight responses without stalling.
module ifu_multi_fetch_inflight_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush_mark,
  output logic [DATA_W-1:0]          head_data,
  output logic                       head_stale,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  stale;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (cnt == CNT_W'(DEPTH));
  assign empty      = (cnt == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_data  = mem[rptr];
  assign head_stale = stale[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // A flush in the same cycle as a push must also mark the new entry.
  always_ff @(posedge clk) begin
    if (flush_mark) stale <= '1;
    if (do_push) begin
      mem[wptr]   <= push_data;
      stale[wptr] <= flush_mark;
    end
  end

endmodule

// File: rtl/ifu_multi.sv
// Instruction fetch unit: issues block-aligned fetches with same-cycle
// prediction truncation, tracks them in order and delivers each group.
module ifu_multi
  import ifu_multi_pkg::*;
#(
  parameter int          FETCH_W         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 ibuf_free,
  input  logic                       raise_excp,
  input  logic [31:0]                excp_target,
  input  logic                       replay,
  input  logic [31:0]                replay_target,
  input  logic                       br_mistaken,
  input  logic [31:0]                right_target,
  input  logic                       idle,
  input  logic                       interrupt,
  output logic                       req_valid,
  output logic [31:0]                req_addr,
  input  logic                       req_ready,
  input  logic                       resp_valid,
  input  logic [FETCH_W*32-1:0]      resp_data,
  input  logic                       resp_excp,
  input  excp_t                      resp_excp_type,
  output logic [31:0]                pred_pc,
  input  logic [FETCH_W-1:0]         pred_taken,
  input  logic [FETCH_W*32-1:0]      pred_target,
  output logic [$clog2(FETCH_W):0]   out_count,
  output logic [31:0]                out_pc,
  output logic [FETCH_W*32-1:0]      out_inst,
  output logic [FETCH_W-1:0]         out_pred_taken,
  output logic [FETCH_W*32-1:0]      out_pred_target,
  output logic                       out_excp,
  output excp_t                      out_excp_type
);

  localparam int CNT_W  = $clog2(FETCH_W) + 1;
  localparam int FCNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ENT_W  = 32 + CNT_W + FETCH_W + FETCH_W * 32 + 1;

  logic [31:0]           pc;
  logic                  idle_state;
  logic                  halted;

  logic [CNT_W-1:0]      off;
  logic [CNT_W-1:0]      words;
  logic [31:0]           issue_next_pc;
  logic                  taken_hit;
  logic [FETCH_W-1:0]    pt_slice;
  logic [FETCH_W*32-1:0] ptgt_slice;

  logic                  redirect;
  logic [31:0]           redirect_target;
  logic                  aligned;
  logic                  space_ok;
  logic                  req_fire;
  logic                  adef_push;
  logic                  fifo_push;
  logic [ENT_W-1:0]      push_data;

  logic [ENT_W-1:0]      head_data;
  logic                  head_stale;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  logic [31:0]           h_pc;
  logic [CNT_W-1:0]      h_words;
  logic [FETCH_W-1:0]    h_pt;
  logic [FETCH_W*32-1:0] h_ptgt;
  logic                  h_adef;
  logic [CNT_W-1:0]      h_off;
  logic [FETCH_W*32-1:0] resp_shift;
  logic                  deliver;
  logic                  excp_halt;

  // Fetch group: truncate at the first predicted-taken slot at or after the PC.
  always_comb begin
    off           = CNT_W'((pc >> 2) & 32'(FETCH_W - 1));
    words         = CNT_W'(FETCH_W) - off;
    taken_hit     = 1'b0;
    issue_next_pc = pc + (32'(words) << 2);
    for (int k = 0; k < FETCH_W; k++) begin
      if (!taken_hit && pred_taken[k] && (CNT_W'(k) >= off)) begin
        taken_hit     = 1'b1;
        words         = CNT_W'(k) - off + CNT_W'(1);
        issue_next_pc = pred_target[k*32 +: 32];
      end
    end
    pt_slice   = pred_taken >> off;
    ptgt_slice = pred_target >> {off, 5'b0};
  end

  assign redirect        = raise_excp || replay || br_mistaken;
  assign redirect_target = raise_excp ? excp_target :
                           replay     ? replay_target : right_target;

  assign aligned   = (pc[1:0] == 2'b00);
  assign space_ok  = (32'(ibuf_free) >= (32'(fifo_cnt) + 32'd1) * 32'(FETCH_W));
  assign req_valid = !reset && !idle_state && !halted && aligned && !fifo_full && space_ok;
  assign req_addr  = blk_align(pc, FETCH_W);
  assign req_fire  = req_valid && req_ready;
  assign pred_pc   = pc;

  // Fault entries enter only an empty tracker, so no memory response can
  // ever be pending behind one when it pops.
  assign adef_push = !reset && !halted && !aligned && fifo_empty;
  assign fifo_push = req_fire || adef_push;
  assign push_data = adef_push ? {pc, CNT_W'(1), {FETCH_W{1'b0}}, {FETCH_W*32{1'b0}}, 1'b1}
                               : {pc, words, pt_slice, ptgt_slice, 1'b0};

  ifu_multi_fetch_inflight_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ENT_W)
  ) u_inflight (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .flush_mark (redirect),
    .head_data  (head_data),
    .head_stale (head_stale),
    .cnt        (fifo_cnt),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign {h_pc, h_words, h_pt, h_ptgt, h_adef} = head_data;
  assign h_off      = CNT_W'((h_pc >> 2) & 32'(FETCH_W - 1));
  assign resp_shift = resp_data >> {h_off, 5'b0};
  assign fifo_pop   = !fifo_empty && (h_adef || resp_valid);
  assign deliver    = fifo_pop && !head_stale && !redirect;
  assign excp_halt  = deliver && !h_adef && resp_excp;

  always_comb begin
    out_count       = '0;
    out_pc          = h_pc;
    out_inst        = '0;
    out_pred_taken  = '0;
    out_pred_target = '0;
    out_excp        = 1'b0;
    out_excp_type   = ADEF;
    if (deliver) begin
      if (h_adef || resp_excp) begin
        out_count      = CNT_W'(1);
        out_excp       = 1'b1;
        out_excp_type  = h_adef ? ADEF : resp_excp_type;
        out_inst[31:0] = NOP_INST;
      end else begin
        out_count = h_words;
        for (int j = 0; j < FETCH_W; j++) begin
          if (CNT_W'(j) < h_words) begin
            out_inst[j*32 +: 32]        = resp_shift[j*32 +: 32];
            out_pred_taken[j]           = h_pt[j];
            out_pred_target[j*32 +: 32] = h_ptgt[j*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      idle_state <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (redirect)      pc <= redirect_target;
      else if (req_fire) pc <= issue_next_pc;

      if (interrupt) idle_state <= 1'b0;
      else if (idle) idle_state <= 1'b1;

      if (redirect)                    halted <= 1'b0;
      else if (adef_push || excp_halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_multi.sv
// Bench for ifu_multi (FETCH_W=4, two outstanding): directed scenarios then
// random traffic, all compared against a transaction-level queue model.
module tb_ifu_multi;
  import ifu_multi_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ibuf_free;
  logic         raise_excp, replay, br_mistaken, idle, interrupt;
  logic [31:0]  excp_target, replay_target, right_target;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr, pred_pc, out_pc;
  logic         resp_valid, resp_excp, out_excp;
  logic [127:0] resp_data, pred_target, out_inst, out_pred_target;
  excp_t        resp_excp_type, out_excp_type;
  logic [3:0]   pred_taken, out_pred_taken;
  logic [2:0]   out_count;

  ifu_multi #(.FETCH_W(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .reset(reset), .ibuf_free(ibuf_free),
    .raise_excp(raise_excp), .excp_target(excp_target),
    .replay(replay), .replay_target(replay_target),
    .br_mistaken(br_mistaken), .right_target(right_target),
    .idle(idle), .interrupt(interrupt),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_excp(resp_excp), .resp_excp_type(resp_excp_type),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .out_count(out_count), .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
    .out_excp(out_excp), .out_excp_type(out_excp_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  pc;
    logic [2:0]   words;
    logic [3:0]   pt;
    logic [127:0] tgt;
    logic         stale;
    logic         adef;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic        m_halted, m_idle;
  ent_t        m_q[$];
  logic [31:0] mem_q[$];

  logic        obs_rv, obs_excp;
  logic [31:0] obs_addr, obs_pc, obs_inst0, obs_ppc, obs_type;
  logic [2:0]  obs_cnt;
  logic [3:0]  obs_pt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [127:0] blk_data(input logic [31:0] a);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = mem_word(a + 32'(4 * i));
    return d;
  endfunction

  // One clock: compare DUT outputs with the model, then advance the model.
  task automatic step();
    logic        redir, exp_rv, pop, dlv, fire, adef_push, found;
    logic [31:0] tgt, nxt;
    int          off, w, exp_cnt, hoff;
    logic        exp_excp;
    ent_t        h, e;
    @(negedge clk);
    #1;
    obs_rv = req_valid; obs_addr = req_addr; obs_cnt = out_count; obs_pc = out_pc;
    obs_excp = out_excp; obs_type = 32'(out_excp_type); obs_inst0 = out_inst[31:0];
    obs_ppc = pred_pc; obs_pt = out_pred_taken;

    redir  = raise_excp || replay || br_mistaken;
    tgt    = raise_excp ? excp_target : (replay ? replay_target : right_target);
    exp_rv = !m_idle && !m_halted && (m_pc[1:0] == 2'b00) && (m_q.size() < 2) &&
             (int'(ibuf_free) >= (m_q.size() + 1) * 4);
    chk("pred_pc", pred_pc, m_pc);
    chk("req_valid", req_valid, exp_rv);
    if (exp_rv) chk("req_addr", req_addr, m_pc & ~32'hF);

    pop      = (m_q.size() > 0) && (m_q[0].adef || resp_valid);
    dlv      = pop && !m_q[0].stale && !redir;
    exp_cnt  = 0;
    exp_excp = 1'b0;
    h        = '0;
    if (dlv) begin
      h = m_q[0];
      if (h.adef || resp_excp) begin
        exp_cnt = 1; exp_excp = 1'b1;
      end else begin
        exp_cnt = int'(h.words);
      end
    end
    chk("out_count", 32'(out_count), 32'(exp_cnt));
    chk("out_excp", out_excp, exp_excp);
    if (exp_cnt != 0) begin
      chk("out_pc", out_pc, h.pc);
      if (exp_excp) begin
        chk("out_excp_type", 32'(out_excp_type), h.adef ? 32'(ADEF) : 32'(resp_excp_type));
        chk("out_nop", out_inst[31:0], NOP_INST);
      end else begin
        hoff = int'(h.pc[3:2]);
        for (int j = 0; j < exp_cnt; j++) begin
          chk("out_inst", out_inst[j*32 +: 32], mem_word(h.pc + 32'(4 * j)));
          chk("out_pred_taken", out_pred_taken[j], h.pt[hoff + j]);
          if (h.pt[hoff + j])
            chk("out_pred_target", out_pred_target[j*32 +: 32], h.tgt[(hoff + j)*32 +: 32]);
        end
      end
    end

    fire      = exp_rv && req_ready;
    adef_push = (m_pc[1:0] != 2'b00) && !m_halted && (m_q.size() == 0);
    if (pop) void'(m_q.pop_front());
    if (resp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    nxt = m_pc;
    if (fire) begin
      off = int'(m_pc[3:2]);
      w = 4 - off;
      nxt = m_pc + 32'(4 * w);
      found = 1'b0;
      for (int k = off; k < 4; k++) begin
        if (!found && pred_taken[k]) begin
          found = 1'b1; w = k - off + 1; nxt = pred_target[k*32 +: 32];
        end
      end
      m_q.push_back('{pc: m_pc, words: 3'(w), pt: pred_taken, tgt: pred_target, stale: 1'b0, adef: 1'b0});
      mem_q.push_back(m_pc & ~32'hF);
    end
    if (adef_push) m_q.push_back('{pc: m_pc, words: 3'd1, pt: 4'd0, tgt: 128'd0, stale: 1'b0, adef: 1'b1});
    if (redir) begin
      for (int i = 0; i < m_q.size(); i++) begin
        e = m_q[i]; e.stale = 1'b1; m_q[i] = e;
      end
    end
    if (redir) m_halted = 1'b0;
    else if (adef_push || (dlv && !h.adef && resp_excp)) m_halted = 1'b1;
    m_pc = redir ? tgt : nxt;
    if (interrupt) m_idle = 1'b0;
    else if (idle) m_idle = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    raise_excp = 0; replay = 0; br_mistaken = 0; idle = 0; interrupt = 0;
    resp_valid = 0; resp_excp = 0; resp_excp_type = I_TLBR; resp_data = '0;
    pred_taken = '0; pred_target = '0;
  endtask

  task automatic redirect_br(input logic [31:0] t);
    br_mistaken = 1; right_target = t;
    step();
    br_mistaken = 0;
  endtask

  task automatic respond();
    resp_valid = (mem_q.size() > 0);
    resp_data  = (mem_q.size() > 0) ? blk_data(mem_q[0]) : '0;
    step();
    resp_valid = 0;
  endtask

  function automatic logic [31:0] rnd_target();
    return 32'h1c000000 + (32'($urandom_range(0, 511)) << 2) + (($urandom % 16 == 0) ? 32'd2 : 32'd0);
  endfunction

  initial begin
    quiet_inputs();
    excp_target = '0; replay_target = '0; right_target = '0;
    ibuf_free = 0; req_ready = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_excp", out_excp, 1'b0);
    chk("rst_pred_pc", pred_pc, 32'h1c000000);
    @(posedge clk); #1;
    reset = 0;
    m_pc = 32'h1c000000; m_halted = 0; m_idle = 0;

    // Unaligned start inside a block.
    redirect_br(32'h1c000008);
    ibuf_free = 15; req_ready = 1;
    step();
    chk("t1_req_valid", obs_rv, 1'b1);
    chk("t1_req_addr", obs_addr, 32'h1c000000);
    req_ready = 0;
    respond();
    chk("t1_count", 32'(obs_cnt), 32'd2);
    chk("t1_pc", obs_pc, 32'h1c000008);
    chk("t1_inst0", obs_inst0, mem_word(32'h1c000008));
    chk("t1_next_addr", obs_addr, 32'h1c000010);

    // Predicted-taken slot 1 truncates the group.
    redirect_br(32'h1c000000);
    pred_taken = 4'b0010; pred_target[63:32] = 32'h1c000100; req_ready = 1;
    step();
    chk("t2_req_addr", obs_addr, 32'h1c000000);
    req_ready = 0; pred_taken = '0; pred_target = '0;
    respond();
    chk("t2_count", 32'(obs_cnt), 32'd2);
    chk("t2_pred_taken", 32'(obs_pt), 32'h2);
    chk("t2_next_addr", obs_addr, 32'h1c000100);

    // Two in flight, then a branch redirect.
    redirect_br(32'h1c000000);
    req_ready = 1;
    step(); step();
    req_ready = 0;
    redirect_br(32'h1c000200);
    respond();
    chk("t3_stale0", 32'(obs_cnt), 32'd0);
    respond();
    chk("t3_stale1", 32'(obs_cnt), 32'd0);
    req_ready = 1;
    step();
    req_ready = 0;
    respond();
    chk("t3_pc", obs_pc, 32'h1c000200);
    chk("t3_count", 32'(obs_cnt), 32'd4);

    // Misaligned redirect target.
    redirect_br(32'h1c000002);
    step();
    chk("t4_no_req", obs_rv, 1'b0);
    step();
    chk("t4_count", 32'(obs_cnt), 32'd1);
    chk("t4_excp", obs_excp, 1'b1);
    chk("t4_type", obs_type, 32'(ADEF));
    chk("t4_nop", obs_inst0, NOP_INST);
    req_ready = 1;
    step();
    chk("t4_halted", obs_rv, 1'b0);
    redirect_br(32'h1c000040);
    step();
    chk("t4_resume", obs_rv, 1'b1);

    // Translation fault on a response.
    req_ready = 0; resp_excp = 1; resp_excp_type = PIF;
    respond();
    resp_excp = 0;
    chk("t5_count", 32'(obs_cnt), 32'd1);
    chk("t5_type", obs_type, 32'(PIF));
    req_ready = 1;
    step();
    chk("t5_halted0", obs_rv, 1'b0);
    step();
    chk("t5_halted1", obs_rv, 1'b0);
    raise_excp = 1; excp_target = 32'h1c000300;
    step();
    raise_excp = 0;
    step();
    chk("t5_resume", obs_rv, 1'b1);
    chk("t5_resume_addr", obs_addr, 32'h1c000300);
    req_ready = 0;
    respond();

    // ibuf space, idle/interrupt, redirect priority.
    ibuf_free = 3; req_ready = 1;
    step();
    chk("t6_ibuf", obs_rv, 1'b0);
    ibuf_free = 15; req_ready = 0; idle = 1;
    step();
    idle = 0; req_ready = 1;
    step();
    chk("t6_idle0", obs_rv, 1'b0);
    step();
    chk("t6_idle1", obs_rv, 1'b0);
    interrupt = 1;
    step();
    interrupt = 0;
    step();
    chk("t6_wake", obs_rv, 1'b1);
    req_ready = 0;
    respond();
    raise_excp = 1; excp_target = 32'h1c000400;
    br_mistaken = 1; right_target = 32'h1c000500;
    step();
    raise_excp = 0; br_mistaken = 0;
    step();
    chk("t6_prio", obs_ppc, 32'h1c000400);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      quiet_inputs();
      raise_excp  = ($urandom % 64 == 0);
      replay      = ($urandom % 64 == 0);
      br_mistaken = ($urandom % 40 == 0);
      excp_target = rnd_target(); replay_target = rnd_target(); right_target = rnd_target();
      idle        = ($urandom % 50 == 0);
      interrupt   = ($urandom % 30 == 0);
      ibuf_free   = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'd15;
      req_ready   = ($urandom % 4 != 0);
      pred_taken  = 4'($urandom & $urandom & $urandom);
      for (int s = 0; s < 4; s++)
        pred_target[s*32 +: 32] = 32'h1c000000 + (32'($urandom_range(0, 511)) << 2);
      if (mem_q.size() > 0 && m_q.size() > 0 && !m_q[0].adef) begin
        resp_valid = ($urandom % 3 != 0);
        resp_data  = blk_data(mem_q[0]);
        resp_excp  = resp_valid && ($urandom % 20 == 0);
        case ($urandom % 3)
          0: resp_excp_type = I_TLBR;
          1: resp_excp_type = PIF;
          default: resp_excp_type = PPI;
        endcase
      end else if (m_q.size() == 0 && $urandom % 8 == 0) begin
        resp_valid = 1;
        resp_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
